// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// The full result is computed on the start edge and parked in shadow
// registers. A down-counter then models the pipeline latency, and the
// shadow values are committed to HI/LO when the count expires. HI/LO
// therefore show the previous result for the whole time busy is high.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             rd_hi,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDUout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_sh, lo_sh;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   ua, ub, uq, ur, q_res, r_res;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Both products at 2*WIDTH bits. Low 2*WIDTH bits of a product of
  // sign-extended operands are the exact signed product.
  always_comb begin
    prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  end

  // Sign-magnitude division. The magnitude of -2^(WIDTH-1) still fits
  // unsigned, so the MIN / -1 case falls out with no special handling.
  always_comb begin
    a_neg = (MDUop == OP_DIV) && A[WIDTH-1];
    b_neg = (MDUop == OP_DIV) && B[WIDTH-1];
    ua    = a_neg ? -A : A;
    ub    = b_neg ? -B : B;
    uq    = (ub == '0) ? '1 : ua / ub;
    ur    = (ub == '0) ? ua : ua % ub;
    q_res = (a_neg ^ b_neg) ? -uq : uq;
    r_res = a_neg ? -ur : ur;
  end

  // Select the result to capture. A zero divisor gives LO = all ones, HI = A.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (MDUop)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (B == '0) begin
          res_hi = A;
          res_lo = '1;
        end else begin
          res_hi = r_res;
          res_lo = q_res;
        end
      end
      default: ;
    endcase
  end

  // Control FSM, latency counter, shadow capture and HI/LO commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_sh <= '0;
      lo_sh <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (MDUop)
              OP_MULT, OP_MULTU: begin
                hi_sh <= res_hi;
                lo_sh <= res_lo;
                cnt   <= CW'(MULT_CYCLES);
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                hi_sh <= res_hi;
                lo_sh <= res_lo;
                cnt   <= CW'(DIV_CYCLES);
                state <= RUN;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        default: begin
          // start is ignored here; the hazard unit stalls on busy
          if (cnt <= CW'(1)) begin
            HI    <= hi_sh;
            LO    <= lo_sh;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // busy comes straight off the state flop, so reset drops it at once.
  assign busy   = (state == RUN);
  assign MDUout = rd_hi ? HI : LO;

endmodule
